// File: rtl/otter_fetch_queue_if.sv
// Fetch-queue bus: redirect input, memory port-1 read side, decode handshake.
// master = fetch queue, slave = core/memory environment.
interface otter_fetch_queue_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 14
);
   localparam int CW = $clog2(DEPTH + 1);

   logic              REDIRECT;
   logic [31:0]       REDIRECT_PC;
   logic              MEM_RDEN;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [31:0]       MEM_DOUT;
   logic              DE_VALID;
   logic              DE_READY;
   logic [31:0]       DE_IR;
   logic [31:0]       DE_PC;
   logic [CW-1:0]     COUNT;

   modport master (
      input  REDIRECT, REDIRECT_PC, MEM_DOUT, DE_READY,
      output MEM_RDEN, MEM_ADDR, DE_VALID, DE_IR, DE_PC, COUNT
   );

   modport slave (
      output REDIRECT, REDIRECT_PC, MEM_DOUT, DE_READY,
      input  MEM_RDEN, MEM_ADDR, DE_VALID, DE_IR, DE_PC, COUNT
   );
endinterface

// File: rtl/otter_fetch_queue.sv
// OTTER prefetch queue: DEPTH-entry {IR,PC} FIFO fed from sync memory port 1.
// Define FETCHQ_BYPASS_EN to forward a returning word straight to decode when empty.
module otter_fetch_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          ADDR_W    = 14
) (
   input logic                  CLK,
   input logic                  RESET,
   otter_fetch_queue_if.master  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic          r_inflight_v;
   logic [31:0]   r_inflight_pc;
   logic [31:0]   r_ir [DEPTH];
   logic [31:0]   r_pc [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [CW:0]   w_occ;
   logic          w_empty;
   logic          w_issue;
   logic          w_byp;
   logic          w_pop;
   logic          w_push;
   logic [31:0]   w_redir_pc;

   // Issue ignores a same-cycle pop, so the FIFO can never overflow.
   assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight_v};
   assign w_empty = (r_count == '0);
   assign w_issue = ~RESET & ~bus.REDIRECT & (w_occ < DEPTH_C);

`ifdef FETCHQ_BYPASS_EN
   assign w_byp = w_empty & r_inflight_v & ~bus.REDIRECT;
`else
   assign w_byp = 1'b0;
`endif

   assign w_pop      = ~w_empty & bus.DE_READY;
   assign w_push     = r_inflight_v & ~bus.REDIRECT & ~(w_byp & bus.DE_READY);
   assign w_redir_pc = bus.REDIRECT_PC & ~32'h3;

   assign bus.MEM_RDEN = w_issue;
   assign bus.MEM_ADDR = r_fetch_pc[ADDR_W+1:2];
   assign bus.DE_VALID = ~w_empty | w_byp;
   assign bus.COUNT    = r_count;

   always_comb begin
      bus.DE_IR = '0;
      bus.DE_PC = '0;
      if (!w_empty) begin
         bus.DE_IR = r_ir[r_head];
         bus.DE_PC = r_pc[r_head];
      end else if (w_byp) begin
         bus.DE_IR = bus.MEM_DOUT;
         bus.DE_PC = r_inflight_pc;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_fetch_pc    <= RESET_VEC;
         r_inflight_v  <= 1'b0;
         r_inflight_pc <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
      end else if (bus.REDIRECT) begin
         r_fetch_pc   <= w_redir_pc;
         r_inflight_v <= 1'b0;
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
      end else begin
         r_inflight_v <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
         end
         if (w_pop)
            r_head <= r_head + PW'(1);
         if (w_push)
            r_tail <= r_tail + PW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; emptiness is tracked by r_count alone.
   always_ff @(posedge CLK) begin
      if (!RESET && w_push) begin
         r_ir[r_tail] <= bus.MEM_DOUT;
         r_pc[r_tail] <= r_inflight_pc;
      end
   end
endmodule
